// File: rtl/cfu_pkg.sv
// Shared types and constants for the CFU operand fetch block:
// FSM state encoding, Wishbone tie-off values and default parameters.
package cfu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    GAP     = 3'd3,
    HOLD    = 3'd4
  } fetch_state_e;

  localparam logic [3:0] SEL_ALL     = 4'b1111;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam int DEFAULT_MAX_RETRY = 3;
  localparam int DEFAULT_TIMEOUT   = 255;

endpackage

// File: rtl/cfu_fetch_timer.sv
// Bus-beat watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT-th enabled cycle.
module cfu_fetch_timer
  import cfu_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  assign expired = enable && (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cfu_operand_fetch.sv
// Fetches an (A, B) operand word pair over a classic Wishbone master port,
// retrying failed beats, and presents the pair with a valid/ready handshake.
module cfu_operand_fetch
  import cfu_pkg::*;
#(
  parameter int MAX_RETRY = DEFAULT_MAX_RETRY,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr_a,
  input  logic [31:0] req_addr_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data_a,
  output logic [31:0] out_data_b,
  output logic        out_err,
  output logic [29:0] cfu_ram_adr,
  output logic [31:0] cfu_ram_dat_mosi,
  output logic [3:0]  cfu_ram_sel,
  output logic        cfu_ram_cyc,
  output logic        cfu_ram_stb,
  output logic        cfu_ram_we,
  output logic [2:0]  cfu_ram_cti,
  output logic [1:0]  cfu_ram_bte,
  input  logic [31:0] cfu_ram_dat_miso,
  input  logic        cfu_ram_ack,
  input  logic        cfu_ram_err
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  fetch_state_e  state_q, state_d;
  logic [29:0]   addr_a_q, addr_a_d;
  logic [29:0]   addr_b_q, addr_b_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          gap_b_q, gap_b_d;
  logic [31:0]   data_a_q, data_a_d;
  logic [31:0]   data_b_q, data_b_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          cyc_q, cyc_d;
  logic [29:0]   adr_q, adr_d;

  logic in_fetch;
  logic beat_fail;
  logic timer_expired;

  // Byte-lane bits of the request addresses have no meaning on a word bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{req_addr_a[1:0], req_addr_b[1:0]};

  assign in_fetch  = (state_q == FETCH_A) || (state_q == FETCH_B);
  assign beat_fail = cfu_ram_err || timer_expired;
  assign req_ready = reset && (state_q == IDLE);

  cfu_fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_fetch || cfu_ram_ack || cfu_ram_err),
    .enable  (in_fetch),
    .expired (timer_expired)
  );

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    retry_d  = retry_q;
    gap_b_d  = gap_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_a_d = req_addr_a[31:2];
          addr_b_d = req_addr_b[31:2];
          retry_d  = '0;
          err_d    = 1'b0;
          state_d  = FETCH_A;
        end
      end
      FETCH_A, FETCH_B: begin
        // err wins over a simultaneous ack; an exhausted budget ends the pair
        if (beat_fail) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            err_d    = 1'b1;
            data_a_d = '0;
            data_b_d = '0;
            state_d  = HOLD;
          end else begin
            retry_d = retry_q + RW'(1);
            gap_b_d = (state_q == FETCH_B);
            state_d = GAP;
          end
        end else if (cfu_ram_ack) begin
          if (state_q == FETCH_A) begin
            data_a_d = cfu_ram_dat_miso;
            retry_d  = '0;
            state_d  = FETCH_B;
          end else begin
            data_b_d = cfu_ram_dat_miso;
            state_d  = HOLD;
          end
        end
      end
      GAP: begin
        state_d = gap_b_q ? FETCH_B : FETCH_A;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus and handshake outputs are registered, so they follow the next state.
    cyc_d   = (state_d == FETCH_A) || (state_d == FETCH_B);
    valid_d = (state_d == HOLD);
    adr_d   = adr_q;
    if (state_d == FETCH_A) begin
      adr_d = addr_a_d;
    end else if (state_d == FETCH_B) begin
      adr_d = addr_b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      retry_q  <= '0;
      gap_b_q  <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      retry_q  <= retry_d;
      gap_b_q  <= gap_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_err          = err_q;
  assign out_data_a       = data_a_q;
  assign out_data_b       = data_b_q;
  assign cfu_ram_cyc      = cyc_q;
  assign cfu_ram_stb      = cyc_q;
  assign cfu_ram_adr      = adr_q;
  assign cfu_ram_sel      = SEL_ALL;
  assign cfu_ram_we       = 1'b0;
  assign cfu_ram_cti      = CTI_CLASSIC;
  assign cfu_ram_bte      = BTE_LINEAR;
  assign cfu_ram_dat_mosi = '0;

endmodule

// File: tb/tb_cfu_operand_fetch.sv
// Randomised bench for cfu_operand_fetch: a scripted Wishbone slave plus a
// transaction-level model of retries, gaps, data and error outcome.
module tb_cfu_operand_fetch;
  import cfu_pkg::*;

  localparam int MAXR = 3;
  localparam int TMO  = 8;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;
  localparam int K_BOTH = 3;

  typedef struct {
    int kind;
    int waits;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr_a = '0;
  logic [31:0] req_addr_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data_a, out_data_b;
  logic        out_err;
  logic [29:0] ram_adr;
  logic [31:0] ram_mosi;
  logic [3:0]  ram_sel;
  logic        ram_cyc, ram_stb, ram_we;
  logic [2:0]  ram_cti;
  logic [1:0]  ram_bte;
  logic [31:0] ram_miso = '0;
  logic        ram_ack = 1'b0;
  logic        ram_err = 1'b0;

  cfu_operand_fetch #(.MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_a(out_data_a), .out_data_b(out_data_b), .out_err(out_err),
    .cfu_ram_adr(ram_adr), .cfu_ram_dat_mosi(ram_mosi), .cfu_ram_sel(ram_sel),
    .cfu_ram_cyc(ram_cyc), .cfu_ram_stb(ram_stb), .cfu_ram_we(ram_we),
    .cfu_ram_cti(ram_cti), .cfu_ram_bte(ram_bte),
    .cfu_ram_dat_miso(ram_miso), .cfu_ram_ack(ram_ack), .cfu_ram_err(ram_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word memory, filled with random contents on first touch.
  logic [31:0] mem [logic [29:0]];
  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic beat_t bt(input int k, input int w);
    beat_t b;
    b.kind  = k;
    b.waits = w;
    return b;
  endfunction

  // Beats the slave will play, and the word addresses the model expects.
  beat_t       plan[$];
  logic [29:0] exp_adr[$];

  logic        in_beat = 1'b0;
  beat_t       cur;
  int          wcnt = 0;
  logic [29:0] cur_adr = '0;

  always @(negedge clk) begin
    ram_ack  = 1'b0;
    ram_err  = 1'b0;
    ram_miso = 32'hDEAD_BEEF;
    if (ram_cyc === 1'b1 && ram_stb === 1'b1) begin
      if (!in_beat) begin
        in_beat = 1'b1;
        wcnt    = 0;
        cur_adr = ram_adr;
        if (plan.size() > 0) cur = plan.pop_front();
        else cur = bt(K_NONE, 0);
        if (exp_adr.size() > 0) check("beat_adr", ram_adr, exp_adr.pop_front());
        else check("extra_beat", 1, 0);
      end else begin
        check("adr_stable", ram_adr, cur_adr);
      end
      if (cur.kind != K_NONE && wcnt == cur.waits) begin
        ram_ack = (cur.kind != K_ERR);
        ram_err = (cur.kind != K_ACK);
        if (ram_ack) ram_miso = mem_rd(ram_adr);
        in_beat = 1'b0;
      end
      wcnt++;
    end else begin
      if (in_beat && cur.kind == K_NONE) check("timeout_len", wcnt, TMO);
      in_beat = 1'b0;
      // noise while the bus is idle must be ignored
      ram_ack = ($urandom_range(0, 3) == 0);
      ram_err = ($urandom_range(0, 3) == 0);
    end
  end

  logic busy = 1'b0;
  int   gap_cycles = 0;
  always @(negedge clk) begin
    if (busy && !ram_cyc && !out_valid) gap_cycles++;
  end

  // One word: random beats until success or until the retry budget is spent.
  function automatic void gen_word(output beat_t q[$]);
    int fails = 0;
    int r, k;
    q = {};
    forever begin
      r = $urandom_range(0, 9);
      k = (r < 6) ? K_ACK : (r < 8) ? K_ERR : (r < 9) ? K_BOTH : K_NONE;
      q.push_back(bt(k, (k == K_NONE) ? 0 : $urandom_range(0, 6)));
      if (k == K_ACK) return;
      fails++;
      if (fails == MAXR + 1) return;
    end
  endfunction

  int txn_no = 0;

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input beat_t pa[$], input beat_t pb[$],
                         input int hold, input int exp_lat);
    logic        e_err;
    logic [31:0] e_da, e_db;
    int          e_gaps, k;
    e_err  = (pa[pa.size()-1].kind != K_ACK) ||
             (pb.size() > 0 && pb[pb.size()-1].kind != K_ACK);
    e_gaps = (pa.size() - 1) + ((pb.size() > 0) ? pb.size() - 1 : 0);
    e_da   = e_err ? 32'h0 : mem_rd(a[31:2]);
    e_db   = e_err ? 32'h0 : mem_rd(b[31:2]);
    foreach (pa[i]) begin plan.push_back(pa[i]); exp_adr.push_back(a[31:2]); end
    foreach (pb[i]) begin plan.push_back(pb[i]); exp_adr.push_back(b[31:2]); end

    @(negedge clk);
    req_valid  = 1'b1;
    req_addr_a = a;
    req_addr_b = b;
    gap_cycles = 0;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    busy      = 1'b1;
    k = 0;
    while (!out_valid && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    busy = 1'b0;
    check("out_valid", out_valid, 1);
    // out_valid first seen after edge T+k is sampled high at edge T+k+1
    if (exp_lat >= 0) check("latency", k + 1, exp_lat);
    check("out_err", out_err, e_err);
    check("data_a", out_data_a, e_da);
    check("data_b", out_data_b, e_db);
    check("gap_cycles", gap_cycles, e_gaps);
    check("beats_left", plan.size(), 0);
    check("cyc_in_hold", ram_cyc, 0);
    check("req_ready_hold", req_ready, 0);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", {out_data_a, out_data_b}, {e_da, e_db});
      check("hold_err", out_err, e_err);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_dropped", out_valid, 0);
    check("req_ready_back", req_ready, 1);
    plan.delete();
    exp_adr.delete();
    $display("txn %0d a=%08h b=%08h beats=%0d err=%0b data=%08h/%08h",
             txn_no, a, b, pa.size() + pb.size(), out_err, out_data_a, out_data_b);
    txn_no++;
  endtask

  initial begin
    beat_t pa[$];
    beat_t pb[$];
    int    k;

    // Reset state and bus constants
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", ram_cyc, 0);
    check("rst_stb", ram_stb, 0);
    check("rst_adr", ram_adr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", out_err, 0);
    check("rst_data", {out_data_a, out_data_b}, 64'h0);
    check("rst_req_ready", req_ready, 0);
    check("tie_sel", ram_sel, 4'hF);
    check("tie_we", ram_we, 0);
    check("tie_cti", ram_cti, 0);
    check("tie_bte", ram_bte, 0);
    check("tie_mosi", ram_mosi, 0);
    @(negedge clk);
    reset = 1'b1;

    mem[30'h40] = 32'h1122_3344;
    mem[30'h81] = 32'h80FF_7F01;

    // Zero-wait fetch
    pa = {}; pb = {};
    pa.push_back(bt(K_ACK, 0)); pb.push_back(bt(K_ACK, 0));
    run_txn(32'h100, 32'h204, pa, pb, 0, 3);

    // Five wait states on each beat
    pa = {}; pb = {};
    pa.push_back(bt(K_ACK, 5)); pb.push_back(bt(K_ACK, 5));
    run_txn(32'h100, 32'h204, pa, pb, 0, -1);

    // One error on A, then success
    pa = {}; pb = {};
    pa.push_back(bt(K_ERR, 0)); pa.push_back(bt(K_ACK, 0)); pb.push_back(bt(K_ACK, 0));
    run_txn(32'h100, 32'h204, pa, pb, 0, -1);

    // Persistent error on A: MAXR+1 attempts, no B fetch
    pa = {}; pb = {};
    repeat (MAXR + 1) pa.push_back(bt(K_ERR, 0));
    run_txn(32'h100, 32'h204, pa, pb, 0, -1);

    // No slave response at all: repeated timeouts
    pa = {}; pb = {};
    repeat (MAXR + 1) pa.push_back(bt(K_NONE, 0));
    run_txn(32'h100, 32'h204, pa, pb, 0, -1);

    // ack and err together on B count as err, then B exhausts its budget
    pa = {}; pb = {};
    pa.push_back(bt(K_ACK, 1));
    repeat (MAXR + 1) pb.push_back(bt(K_BOTH, 2));
    run_txn(32'h100, 32'h204, pa, pb, 0, -1);

    // Backpressure for ten cycles
    pa = {}; pb = {};
    pa.push_back(bt(K_ACK, 2)); pb.push_back(bt(K_ACK, 0));
    run_txn(32'h100, 32'h204, pa, pb, 10, -1);

    // Reset during FETCH_B
    plan.push_back(bt(K_ACK, 0)); exp_adr.push_back(30'h40);
    plan.push_back(bt(K_ACK, 6)); exp_adr.push_back(30'h81);
    @(negedge clk);
    req_valid = 1'b1; req_addr_a = 32'h100; req_addr_b = 32'h204;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!(ram_cyc && ram_adr == 30'h81) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("reached_fetch_b", ram_cyc && ram_adr == 30'h81, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_cyc", ram_cyc, 0);
    check("mid_rst_stb", ram_stb, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    check("mid_rst_adr", ram_adr, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_valid", out_valid, 0);
    plan.delete();
    exp_adr.delete();
    $display("txn %0d reset during FETCH_B", txn_no);
    txn_no++;

    // Random traffic
    repeat (40) begin
      gen_word(pa);
      pb = {};
      if (pa[pa.size()-1].kind == K_ACK) gen_word(pb);
      run_txn($urandom, $urandom, pa, pb, $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cfu_operand_fetch.md
CFU_OPERAND_FETCH -- requirements
Module: cfu_operand_fetch

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: number of re-issues allowed per word after a bus error or timeout.
REQ-002 SHALL have parameter TIMEOUT, default 255: number of cycles with cyc=1 and no ack/err before a timeout is declared.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, active-low and synchronous (0 = reset, sampled on the clk rising edge).
REQ-005 SHALL have port req_valid  in  1  an operand-pair request is present.
REQ-006 SHALL have port req_ready  out  1  the block accepts a request this cycle.
REQ-007 SHALL have ports req_addr_a and req_addr_b  in  32 each  byte addresses of the matrix word (A) and the filter word (B).
REQ-008 SHALL have port out_valid  out  1  the operand pair is available.
REQ-009 SHALL have port out_ready  in  1  the downstream MAC stage takes the pair.
REQ-010 SHALL have ports out_data_a and out_data_b  out  32 each  fetched words.
REQ-011 SHALL have port out_err  out  1  the retry budget was exhausted; valid only while out_valid=1.
REQ-012 SHALL have Wishbone master ports cfu_ram_adr out 30, cfu_ram_dat_mosi out 32, cfu_ram_sel out 4, cfu_ram_cyc out 1, cfu_ram_stb out 1, cfu_ram_we out 1, cfu_ram_cti out 3, cfu_ram_bte out 2, cfu_ram_dat_miso in 32, cfu_ram_ack in 1, cfu_ram_err in 1.

Function
REQ-013 SHALL tie the bus constants as follows: sel=4'b1111, we=0, cti=0, bte=0, dat_mosi=0.
REQ-014 SHALL use the states IDLE, FETCH_A, FETCH_B, GAP and HOLD, all registered.
REQ-015 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready it SHALL latch both addresses and move to FETCH_A.
REQ-016 SHALL, in FETCH_A and FETCH_B, drive cyc=stb=1 with adr equal to the latched address bits [31:2]; address bits [1:0] are ignored.
REQ-017 SHALL, on ack in FETCH_A, capture dat_miso into A and go to FETCH_B with cyc held high (back-to-back beats).
REQ-018 SHALL, on ack in FETCH_B, capture dat_miso into B, go to HOLD and drop cyc/stb.
REQ-019 SHALL treat ack and err asserted in the same cycle as err.
REQ-020 SHALL treat err, or a timeout (TIMEOUT cycles of cyc=1 without ack or err), as a failed beat: the per-word retry count increments and the block goes to GAP.
REQ-021 SHALL, in GAP, hold cyc=stb=0 for exactly one cycle and then re-enter the failed FETCH state with the same address.
REQ-022 SHALL, when a beat fails while the retry count already equals MAX_RETRY, go to HOLD with out_err=1 and out_data_a and out_data_b both 0.
REQ-023 SHALL reset the retry count and the timeout counter on entry to each FETCH state.
REQ-024 SHALL drive out_valid=1 only in HOLD, keeping data and out_err stable until out_valid&&out_ready, after which it returns to IDLE.
REQ-025 SHALL have a minimum latency, with zero-wait ack, of: accept at edge T, ack A sampled at T+1, ack B sampled at T+2, out_valid=1 from T+3.
REQ-026 SHALL ignore ack/err while cyc=0.

Reset
REQ-027 SHALL, while reset=0 at a clk edge, set state=IDLE, cyc=stb=0, adr=0, out_valid=0, out_err=0, out_data_a=out_data_b=0, and clear all counters.
REQ-028 SHALL, on reset asserted mid-transaction, have cyc/stb low from the next edge, discard any in-flight data, and signal no out_valid.
REQ-029 SHALL drive req_ready=0 while reset=0 is sampled.

Structure
REQ-030 SHALL place the state enum, the bus tie-off constants (SEL_ALL, CTI_CLASSIC, BTE_LINEAR) and the default MAX_RETRY/TIMEOUT values in the shared package cfu_pkg.
REQ-031 SHALL implement the timeout counter (clear, enable, expired) as the sub-module cfu_fetch_timer.
REQ-032 SHALL keep all outputs registered except req_ready, which SHALL be decoded from state only.

Verification
REQ-033 SHALL cover zero-wait fetch: A=0x100 returns 0x11223344 and B=0x204 returns 0x80FF7F01 -> out_valid=1 three cycles after accept, with both data words matching and out_err=0.
REQ-034 SHALL cover wait states: ack delayed 5 cycles on each beat -> cyc stays high throughout, adr=0x40 then 0x81, and the data is correct.
REQ-035 SHALL cover one error on A: err on the first beat, ack on the second -> exactly one cyc=0 gap cycle, then correct data with out_err=0.
REQ-036 SHALL cover persistent error: err on every beat with MAX_RETRY=3 -> 4 attempts on A, out_valid=1, out_err=1, data 0, and no B fetch.
REQ-037 SHALL cover timeout: TIMEOUT=8 with no slave response -> a gap after 8 cycles, then retries, ending with out_err=1.
REQ-038 SHALL cover backpressure and reset: out_ready=0 for 10 cycles holds data stable; reset=0 during FETCH_B drops cyc the next cycle and gives out_valid=0 and req_ready=1 after release.
